// File: rtl/pipeline_dmem_responder_if.sv
// Load/store request and response bus between the CPU MEM stage (master) and the data memory (slave).
interface pipeline_dmem_responder_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/pipeline_dmem_responder.sv
// Fixed-latency data-memory responder: one word load or byte-masked store at a time, response held until consumed.
// Optional macro DMEM_MISALIGN_CHECK_EN: treat addr[1:0] != 0 as a fault instead of ignoring it.
module pipeline_dmem_responder #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pipeline_dmem_responder_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned LANES = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [LANES-1:0]    be_q;
    logic                ready_q;
    logic                valid_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [DEPTH_LOG2-1:0] idx_c;
    logic                  fault_c;
    logic                  commit_c;
    logic                  mem_wr_c;

    assign idx_c = addr_q[DEPTH_LOG2+1:2];

    // Any address bit above the word index range means the word does not exist.
`ifdef DMEM_MISALIGN_CHECK_EN
    assign fault_c = ((addr_q >> (DEPTH_LOG2 + 2)) != '0) || (addr_q[1:0] != 2'b00);
`else
    assign fault_c = ((addr_q >> (DEPTH_LOG2 + 2)) != '0);
`endif

    assign commit_c = (state == WAIT) && (cnt == '0);
    assign mem_wr_c = rst_n && commit_c && we_q && !fault_c;

    // Array is never reset; a store lands on the same edge its response is committed.
    always_ff @(posedge clk) begin
        if (mem_wr_c) begin
            for (int i = 0; i < LANES; i++) begin
                if (be_q[i]) begin
                    mem[idx_c][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        we_q    <= bus.req_we;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        be_q    <= bus.req_be;
                        cnt     <= CNT_W'(LATENCY - 1);
                        ready_q <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        valid_q <= 1'b1;
                        err_q   <= fault_c;
                        rdata_q <= (we_q || fault_c) ? '0 : mem[idx_c];
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_pipeline_dmem_responder.sv
// Scoreboard bench for pipeline_dmem_responder: driver pushes expected responses, monitor pops on handshake.
module tb_pipeline_dmem_responder;
    localparam int unsigned LAT = 3;
    localparam int unsigned DL  = 8;
    localparam int unsigned NW  = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_dmem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    pipeline_dmem_responder #(
        .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(DL), .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [NW];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          hold_low = 1'b0;
    bit          seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Consumer readiness: random, or forced low to apply backpressure.
    always @(posedge clk) begin
        #2;
        bus.resp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: every cycle a response is visible it must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (bus.resp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_resp_valid", 32'(bus.resp_valid), 32'd0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", 32'(cyc - q[0].acc), 32'(LAT));
                end
                chk("resp_rdata", bus.resp_rdata, q[0].rdata);
                chk("resp_err", 32'(bus.resp_err), 32'(q[0].err));
                chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
                if (bus.resp_ready) begin
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic wait_done();
        int t = 0;
        while (q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) chk("resp_timeout", 32'(q.size()), 32'd0);
    endtask

    // Issue one request; the reference model is updated at accept time.
    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input bit keep, input bit abort);
        exp_t        e;
        int unsigned idx;
        bit          fault;
        int          t = 0;
        @(negedge clk);
        while (!bus.req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready) chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        @(posedge clk);
        #1;
        chk("req_ready_after_accept", 32'(bus.req_ready), 32'd0);
        if (abort) begin
            rst_n = 1'b0;
            bus.req_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
            chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
            rst_n = 1'b1;
            return;
        end
        idx   = addr >> 2;
        fault = (idx >= NW);
`ifdef DMEM_MISALIGN_CHECK_EN
        if (addr[1:0] != 2'b00) fault = 1'b1;
`endif
        e.err   = fault;
        e.rdata = 32'd0;
        e.acc   = cyc;
        if (!fault) begin
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) model[idx][8*i +: 8] = wdata[8*i +: 8];
            end else begin
                e.rdata = model[idx];
            end
        end
        q.push_back(e);
        if (!keep) begin
            bus.req_valid = 1'b0;
            bus.req_we    = 1'($urandom);
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int unsigned sel;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        rst_n = 1'b1;

        // Give every word a known value.
        for (int i = 0; i < NW; i++) begin
            do_req(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, 1'b0);
            wait_done();
        end

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0); wait_done();
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0);        wait_done();
        chk("store_load_model", model[4], 32'hDEADBEEF);

        do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 1'b0); wait_done();
        do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 1'b0, 1'b0); wait_done();
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0);        wait_done();

        // Backpressure with the request line left high: nothing new may be accepted.
        hold_low = 1'b1;
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
        repeat (LAT + 5) @(negedge clk);
        chk("bp_resp_valid_held", 32'(bus.resp_valid), 32'd1);
        bus.req_valid = 1'b0;
        hold_low = 1'b0;
        wait_done();
        @(posedge clk);
        #1;
        chk("bp_idle_req_ready", 32'(bus.req_ready), 32'd1);
        chk("bp_idle_resp_valid", 32'(bus.resp_valid), 32'd0);

        do_req(1'b0, 32'h400, 32'h0, 4'h0, 1'b0, 1'b0);       wait_done();
        do_req(1'b1, 32'h12, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0); wait_done();
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0);        wait_done();
        do_req(1'b1, 32'h10, 32'h01234567, 4'h0, 1'b0, 1'b0); wait_done();
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0);        wait_done();

        // Store aborted by reset one edge after accept must not write.
        do_req(1'b1, 32'h30, 32'h55, 4'hF, 1'b0, 1'b1);
        repeat (LAT + 3) @(negedge clk);
        do_req(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 1'b0);        wait_done();

        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) a = $urandom;
            else a = (32'($urandom_range(0, NW - 1)) << 2) | ((sel == 1) ? 32'($urandom_range(1, 3)) : 32'd0);
            do_req(1'($urandom), a, $urandom, 4'($urandom), 1'b0, 1'b0);
            wait_done();
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_dmem_responder.md
# pipeline_dmem_responder

Data-memory responder for the pipeline CPU: the memory end of the load/store request interface driven by the CPU's MEM stage. Accepts one request at a time over a valid/ready handshake and performs a word read or byte-masked write into an internal synchronous array. Returns the result after a fixed, parameterised latency and holds it until the CPU consumes it. Lets the pipeline's stall logic be exercised against non-zero memory latency.

## Interface
- ADDR_W, 32, byte-address width
- DATA_W, 32, data width; fixed at 32, four byte lanes
- DEPTH_LOG2, 8, log2 of the word count (256 words)
- LATENCY, 2, clock edges from accept to response commit; legal range 1..15
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  CPU presents a request
- req_ready  out  1  responder can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data
- req_be  in  4  store byte enables; bit i covers wdata[8i+7:8i]; ignored for loads
- resp_valid  out  1  response available
- resp_ready  in  1  CPU consumes the response
- resp_rdata  out  DATA_W  load data; 0 for stores and errors
- resp_err  out  1  access faulted; no memory change

## Operation
- States: IDLE, WAIT, RESP. Reset forces IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, cnt=0.
- Memory array contents are not cleared by reset.
- IDLE: when req_valid&&req_ready is sampled high, capture we/addr/wdata/be, load cnt=LATENCY-1, go to WAIT.
- WAIT: req_ready=0. When cnt!=0, decrement cnt. When cnt==0, commit and go to RESP.
- Commit on a load: resp_rdata=mem[addr[DEPTH_LOG2+1:2]].
- Commit on a store: write only the enabled lanes; resp_rdata=0.
- Fault: word index addr[ADDR_W-1:2] >= 2^DEPTH_LOG2. Any fault sets resp_err=1 and resp_rdata=0, with no write.
- RESP: resp_valid=1 and the outputs stay stable until resp_ready is sampled high, then go to IDLE and clear resp_valid. resp_rdata/resp_err hold their last values.
- Store with req_be=0: completes normally with no array change and resp_err=0.
- Inputs are ignored outside the accept edge. A request still asserted during WAIT/RESP is not re-accepted.
- Reset in WAIT: the pending access is abandoned and an uncommitted store never writes. Reset in RESP drops the response.

## Timing
- Accept at edge E0. Commit and entry to RESP at edge E0+LATENCY. resp_valid is high from the cycle after E0+LATENCY.
- If resp_ready is already high, resp_valid lasts one cycle and IDLE is re-entered at edge E0+LATENCY+1.
- Back-to-back throughput: one access per LATENCY+2 cycles. req_ready returns high in the cycle after the resp_ready handshake.
- A load that follows a store to the same word sees the stored data, because the store commits before the store's RESP.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Configuration
- DMEM_MISALIGN_CHECK_EN defined: addr[1:0]!=0 is also a fault and sets resp_err=1 with no write. Latency is unchanged.
- DMEM_MISALIGN_CHECK_EN undefined: addr[1:0] is ignored and the access goes to the containing word.

## Test plan
- Reset, then idle: rst_n=0 for 2 edges -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Store then load, LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, be=0xF. Then load 0x10 -> resp_valid exactly 2 edges after each accept, load resp_rdata=0xDEADBEEF, resp_err=0.
- Byte masking: word 0x20=0x11223344, store wdata 0xAABBCCDD with be=0b0101 -> load returns 0x11BB33DD.
- Backpressure: hold resp_ready=0 for 5 cycles after a load of 0x10 -> resp_valid and resp_rdata stay stable, req_ready=0 and a new req_valid is not accepted. Raise resp_ready -> IDLE one edge later.
- Faults: load addr 0x400 with DEPTH_LOG2=8 -> resp_err=1, resp_rdata=0. Store to 0x12 -> with DMEM_MISALIGN_CHECK_EN: resp_err=1 and word 0x10 unchanged. Without the macro: word 0x10 written, resp_err=0.
- Reset mid-op: accept a store of 0x55 to 0x30 with LATENCY=3, then rst_n=0 at edge E0+1 -> a later load of 0x30 returns the old value and no resp_valid appears for the aborted store.
